// File: rtl/data_mem_unit.sv
// -----------------------------------------------------------------------------
// data_mem_unit
//   Byte-addressable data memory for the single-cycle RV32I core. The ALU
//   result is the effective address. The unit performs lb/lh/lw/lbu/lhu loads,
//   which are combinational and extended to N bits, and sb/sh/sw stores, which
//   are written on the rising edge. It flags misaligned accesses, suppresses
//   misaligned stores, and latches the address of the first misaligned access.
//
//   There is no valid/ready handshake. A request is MemRead and/or MemWrite
//   being high in a cycle. It always completes in that same cycle, and the
//   unit never stalls.
//
// Ports
//   clk        processor clock, rising-edge state updates
//   reset      synchronous active-high reset (clears array and error capture)
//   Addr       byte address; upper bits beyond the array span are ignored
//   WriteData  store data (rs2)
//   MemWrite   store request this cycle
//   MemRead    load request this cycle
//   Funct3     000 b, 001 h, 010 w, 100 bu, 101 hu (others unsupported)
//   ReadData   extended load data, combinational (0 when not a legal load)
//   Misaligned current request is misaligned, combinational
//   ErrSticky  a misaligned access has occurred since reset
//   ErrAddr    Addr of the first misaligned access since reset
// -----------------------------------------------------------------------------
module data_mem_unit #(
  parameter int N           = 32,
  parameter int DEPTH_WORDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] Addr,
  input  logic [N-1:0] WriteData,
  input  logic         MemWrite,
  input  logic         MemRead,
  input  logic [2:0]   Funct3,
  output logic [N-1:0] ReadData,
  output logic         Misaligned,
  output logic         ErrSticky,
  output logic [N-1:0] ErrAddr
);

  // Byte-address width of the array span; the word index sits above the lane.
  localparam int AW = $clog2(4 * DEPTH_WORDS);
  localparam int WI = AW - 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [WI-1:0] word_idx;
  logic [1:0]    lane;
  logic          is_half;
  logic          is_word;
  logic          req;
  logic [31:0]   cur_word;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic          store_ok;
  logic [3:0]    byte_en;

  assign word_idx = Addr[AW-1:2];
  assign lane     = Addr[1:0];
  assign req      = MemRead | MemWrite;
  assign is_half  = (Funct3 == F3_H) || (Funct3 == F3_HU);
  assign is_word  = (Funct3 == F3_W);

  // Byte accesses can never be misaligned. Unsupported Funct3 codes are not
  // flagged either; they are simply inert.
  assign Misaligned = req & ((is_half & Addr[0]) | (is_word & (lane != 2'b00)));

  // Read-before-write: the read path sees the array as it stood before this edge.
  assign cur_word = mem[word_idx];
  assign sel_byte = cur_word[8*lane +: 8];
  assign sel_half = Addr[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    ReadData = '0;
    if (MemRead && !Misaligned) begin
      case (Funct3)
        F3_B:    ReadData = {{(N-8){sel_byte[7]}}, sel_byte};
        F3_H:    ReadData = {{(N-16){sel_half[15]}}, sel_half};
        F3_W:    ReadData = N'(cur_word);
        F3_BU:   ReadData = {{(N-8){1'b0}}, sel_byte};
        F3_HU:   ReadData = {{(N-16){1'b0}}, sel_half};
        default: ReadData = '0;
      endcase
    end
  end

  // Only the signed store encodings are legal stores. A misaligned store
  // writes nothing, so no lane is ever partially updated.
  assign store_ok = MemWrite && !Misaligned &&
                    ((Funct3 == F3_B) || (Funct3 == F3_H) || (Funct3 == F3_W));

  always_comb begin
    byte_en = 4'b0000;
    if (store_ok) begin
      case (Funct3)
        F3_B:    byte_en = 4'b0001 << lane;
        F3_H:    byte_en = Addr[1] ? 4'b1100 : 4'b0011;
        F3_W:    byte_en = 4'b1111;
        default: byte_en = 4'b0000;
      endcase
    end
  end

  // Sub-word stores take their data from the low bits of WriteData,
  // replicated into whichever lane(s) are enabled.
  logic [31:0] wr_word;
  always_comb begin
    wr_word = WriteData[31:0];
    case (Funct3)
      F3_B:    wr_word = {4{WriteData[7:0]}};
      F3_H:    wr_word = {2{WriteData[15:0]}};
      default: wr_word = WriteData[31:0];
    endcase
  end

  // Memory array: reset clears every word and takes priority over a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          mem[word_idx][8*k +: 8] <= wr_word[8*k +: 8];
        end
      end
    end
  end

  // First-error capture: once set, the sticky flag freezes ErrAddr until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ErrSticky <= 1'b0;
      ErrAddr   <= '0;
    end else if (Misaligned && !ErrSticky) begin
      ErrSticky <= 1'b1;
      ErrAddr   <= Addr;
    end
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Byte-addressable data memory stage directly downstream of the ALU in the RISC-V single-cycle processor. It takes the ALU `Result` as the effective address and performs RV32I loads and stores (byte, halfword, word, signed and unsigned). It returns load data, already sign- or zero-extended, for the write-back mux. It also detects misaligned accesses, blocks misaligned stores, and latches the address of the first misaligned access for debug.

## Interface
Parameters:
- `N`, 32, data and address width.
- `DEPTH_WORDS`, 64, number of 32-bit words; a power of two, at least 2; byte span = 4*DEPTH_WORDS.

Ports:
- `clk`  input  1  processor clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `Addr`  input  N  byte address (ALU `Result`).
- `WriteData`  input  N  store data (rs2 value).
- `MemWrite`  input  1  store request this cycle.
- `MemRead`  input  1  load request this cycle.
- `Funct3`  input  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `ReadData`  output  N  extended load data, combinational.
- `Misaligned`  output  1  current access is misaligned, combinational.
- `ErrSticky`  output  1  a misaligned access has occurred since reset.
- `ErrAddr`  output  N  `Addr` of the first misaligned access.

## Operation
- Word index = `Addr[log2(4*DEPTH_WORDS)-1:2]`, byte lane = `Addr[1:0]`.
- Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Misaligned = (`MemRead` | `MemWrite`) & (h/hu with `Addr[0]`=1, or w with `Addr[1:0]`≠0).
- Byte accesses are never misaligned. `Misaligned`=0 when no request is active.
- Loads (`MemRead`=1, aligned):
  - lb/lbu select lane `Addr[1:0]`. lh/lhu select the half chosen by `Addr[1]`. lw returns the full word.
  - lb/lh sign-extend to N; lbu/lhu zero-extend.
- `ReadData` = 0 when `MemRead`=0, when the access is misaligned, or when `Funct3` is unsupported (011, 110, 111).
- Stores (`MemWrite`=1, aligned, legal `Funct3` 000/001/010):
  - At the rising edge, write byte enables: sb → lane `Addr[1:0]` from `WriteData[7:0]`; sh → lanes {1,0} or {3,2} from `WriteData[15:0]`; sw → all lanes.
  - Unselected lanes are unchanged.
- Misaligned stores and stores with unsupported `Funct3` write nothing. No partial writes.
- `MemRead` and `MemWrite` both 1: the store executes; `ReadData` shows the pre-store contents that cycle (read-before-write).
- Error capture: at the rising edge, if `Misaligned`=1 and `ErrSticky`=0, set `ErrSticky`=1 and `ErrAddr`=`Addr`. Later misaligned accesses do not overwrite `ErrAddr`. Both hold until reset.
- Reset (rising edge with `reset`=1):
  - Clears every memory word to 0 and sets `ErrSticky`=0, `ErrAddr`=0.
  - Takes priority over any store or error capture in the same cycle.

## Timing
- Load path is combinational: `ReadData` and `Misaligned` are valid in the same cycle as `Addr`/`Funct3`/`MemRead`, with zero latency.
- Store latency is one edge: data is readable in the cycle after the write edge.
- `ErrSticky`/`ErrAddr` update one edge after the misaligned access.
- Reset values: memory all 0, `ErrSticky`=0, `ErrAddr`=0. During reset, `ReadData` is combinational on the array; it reads 0 from the cycle after the reset edge.
- Reset asserted mid-sequence: a store in the reset cycle is discarded, and the array is zero on the next cycle.
- No handshake: every request completes in its own cycle, and the block never stalls.

## Test plan
- After reset, sw 0x8000_00FF to 0x10 -> next cycle: lw 0x10 = 0x8000_00FF; lb 0x10 = 0xFFFF_FFFF; lbu 0x10 = 0x0000_00FF; lh 0x12 = 0xFFFF_8000; lhu 0x12 = 0x0000_8000.
- sw 0 to 0x20, then sb 0xAB to 0x21, then sh 0x1234 to 0x22 -> lw 0x20 = 0x1234_AB00.
- sw 0x1111_1111 to 0x30, then sw 0xDEAD_BEEF to 0x32 -> `Misaligned`=1 in the store cycle; memory unchanged (lw 0x30 = 0x1111_1111); `ErrSticky`=1 and `ErrAddr`=0x32 next cycle. A later lh at 0x41 leaves `ErrAddr`=0x32.
- lw 0x30 = 0x1111_1111, then MemRead=1, MemWrite=1, sw 0x5555_5555 to 0x30 in one cycle -> `ReadData`=0x1111_1111 in that cycle; next-cycle lw 0x30 = 0x5555_5555.
- `DEPTH_WORDS`=64: sw 0xCAFE_F00D to 0x104 -> lw 0x004 = 0xCAFE_F00D (wrap-around). Funct3=011 load -> `ReadData`=0.
- Assert `reset` while sw 0x7 to 0x8 is presented -> lw 0x8 = 0 after reset deasserts; `ErrSticky`=0 and `ErrAddr`=0.
